// File: rtl/tone_mixer_if.sv
// tone_mixer_if: bundle between the sequencer/codec side and tone_mixer.
//   trig   [15:0] note triggers (bit i starts voice i on its rising level)
//   mute          synchronous kill of all voices
//   sample [15:0] signed mixed audio, registered in the mixer
//   active [15:0] bit i high while voice i is sounding
// Handshake: there is no valid/ready. trig is edge-sensitive: a bit that
// goes from 0 to 1 between two sampling edges starts its voice exactly
// once. sample and active are updated on every clock edge.
// master: sequencer/bench side. slave: tone_mixer side.
interface tone_mixer_if;
  logic        [15:0] trig;
  logic               mute;
  logic signed [15:0] sample;
  logic        [15:0] active;

  modport master (output trig, output mute, input sample, input active);
  modport slave  (input trig, input mute, output sample, output active);
endinterface

// File: rtl/tone_mixer.sv
// tone_mixer: sixteen fixed-pitch square-wave voices summed into one signed
// 16-bit sample per clock.
//   clock   sample-rate clock, rising edge
//   resetn  synchronous active-low reset
//   bus     tone_mixer_if.slave (trig, mute in; sample, active out)
// Voice i has half-period BASE_HALF - i*HALF_STEP clocks and lasts NOTE_LEN
// clocks after its trigger. The summed contributions saturate to
// [-32767, +32767] before being registered into sample.
// Optional build macro TONE_MIXER_ENVELOPE_EN: magnitude decays by halves
// over each quarter of the note instead of staying at AMP.
module tone_mixer #(
  parameter int BASE_HALF = 100,
  parameter int HALF_STEP = 5,
  parameter int NOTE_LEN  = 11025,
  parameter int AMP       = 2047
) (
  input  logic         clock,
  input  logic         resetn,
  tone_mixer_if.slave  bus
);

  logic [15:0]       trig_prev;
  logic [15:0]       trig_edge;
  logic [15:0][6:0]  phase;
  logic [15:0]       level;
  logic [15:0][13:0] dur;

  logic signed [19:0] mag [16];
  logic signed [19:0] sum;
  logic signed [15:0] sat;

  // Last phase value before a toggle for voice i.
  function automatic logic [6:0] half_m1(input int i);
    return 7'(BASE_HALF - i * HALF_STEP - 1);
  endfunction

  assign trig_edge = bus.trig & ~trig_prev;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      trig_prev <= '0;
      phase     <= '0;
      level     <= '0;
      dur       <= '0;
    end else begin
      // History updates even while muted so a held level never re-fires.
      trig_prev <= bus.trig;
      for (int i = 0; i < 16; i++) begin
        if (bus.mute) begin
          dur[i]   <= '0;
          phase[i] <= '0;
          level[i] <= 1'b0;
        end else if (trig_edge[i]) begin
          dur[i]   <= 14'(NOTE_LEN);
          phase[i] <= '0;
          level[i] <= 1'b1;
        end else if (dur[i] != '0) begin
          dur[i] <= dur[i] - 14'd1;
          if (phase[i] == half_m1(i)) begin
            phase[i] <= '0;
            level[i] <= ~level[i];
          end else begin
            phase[i] <= phase[i] + 7'd1;
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      bus.active[i] = (dur[i] != '0);
    end
  end

`ifdef TONE_MIXER_ENVELOPE_EN
  localparam int Q = NOTE_LEN / 4;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      if (dur[i] > 14'(3 * Q)) begin
        mag[i] = 20'(AMP);
      end else if (dur[i] > 14'(2 * Q)) begin
        mag[i] = 20'(AMP >> 1);
      end else if (dur[i] > 14'(Q)) begin
        mag[i] = 20'(AMP >> 2);
      end else begin
        mag[i] = 20'(AMP >> 3);
      end
    end
  end
`else
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      mag[i] = 20'(AMP);
    end
  end
`endif

  // 16 voices of at most 15-bit magnitude fit comfortably in 20 bits.
  always_comb begin
    sum = '0;
    for (int i = 0; i < 16; i++) begin
      if (dur[i] != '0) begin
        sum = level[i] ? (sum + mag[i]) : (sum - mag[i]);
      end
    end
  end

  // Symmetric clamp: -32768 is deliberately never produced.
  always_comb begin
    if (sum > 20'sd32767) begin
      sat = 16'sd32767;
    end else if (sum < -20'sd32767) begin
      sat = -16'sd32767;
    end else begin
      sat = sum[15:0];
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      bus.sample <= '0;
    end else begin
      bus.sample <= sat;
    end
  end

endmodule

// File: tb/tb_tone_mixer.sv
// tb_tone_mixer: directed bench for tone_mixer (default build, envelope off).
// A second instance with AMP=4095 exercises saturation.
module tb_tone_mixer;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  tone_mixer_if bus ();
  tone_mixer_if bus2 ();

  tone_mixer dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  tone_mixer #(.AMP(4095)) dut2 (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus2.slave)
  );

  // Clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  int n_checks = 0;
  int n_err    = 0;
  int e        = 0;   // edge offset relative to the current note's trigger
  int bad      = 0;

  // Driver tasks: advance one edge, then settle before observing/driving.
  task automatic tick();
    @(posedge clock);
    #1;
    e++;
  endtask

  task automatic tick_to(input int t);
    while (e < t) tick();
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_v0();
    bus.trig = 16'h0001;
    e = -1;
    tick();
    bus.trig = 16'h0000;
  endtask

  initial begin
    bus.trig  = '0;
    bus.mute  = 1'b0;
    bus2.trig = '0;
    bus2.mute = 1'b0;

    // Reset
    repeat (3) tick();
    check("rst_sample", $signed(bus.sample), 0);
    check("rst_active", {16'h0, bus.active}, 0);
    check("rst_sample2", $signed(bus2.sample), 0);
    resetn = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      check("idle_sample", $signed(bus.sample), 0);
      check("idle_active", {16'h0, bus.active}, 0);
    end

    // Single note on voice 0
    pulse_v0();
    check("note_active_n", {16'h0, bus.active}, 32'h0001);
    check("note_sample_n", $signed(bus.sample), 0);
    for (int k = 1; k <= 100; k++) begin
      tick();
      check("note_high", $signed(bus.sample), 2047);
    end
    for (int k = 101; k <= 200; k++) begin
      tick();
      check("note_low", $signed(bus.sample), -2047);
    end
    tick_to(11024);
    check("note_last_active", {16'h0, bus.active}, 32'h0001);
    tick();
    check("note_end_active", {16'h0, bus.active}, 0);
    check("note_tail_sample", $signed(bus.sample), 2047);
    tick();
    check("note_silent", $signed(bus.sample), 0);

    // Retrigger voice 0 at +5000
    pulse_v0();
    tick_to(4999);
    check("retrig_before", $signed(bus.sample), -2047);
    bus.trig = 16'h0001;
    tick();
    bus.trig = 16'h0000;
    for (int k = 5001; k <= 5100; k++) begin
      tick();
      check("retrig_high", $signed(bus.sample), 2047);
    end
    tick();
    check("retrig_low", $signed(bus.sample), -2047);
    tick_to(11025);
    check("retrig_extended", {16'h0, bus.active}, 32'h0001);
    tick_to(16024);
    check("retrig_last_active", {16'h0, bus.active}, 32'h0001);
    tick();
    check("retrig_end_active", {16'h0, bus.active}, 0);

    // Held chord: voices 0 and 15
    bus.trig = 16'h8001;
    e = -1;
    tick();
    check("chord_active_n", {16'h0, bus.active}, 32'h8001);
    bad = 0;
    for (int k = 1; k <= 11025; k++) begin
      tick();
      if (k == 1)   check("chord_k1", $signed(bus.sample), 4094);
      if (k == 26)  check("chord_k26", $signed(bus.sample), 0);
      if (k == 101) check("chord_k101", $signed(bus.sample), 0);
      if (k == 126) check("chord_k126", $signed(bus.sample), -4094);
      if (k == 11024) check("chord_last_active", {16'h0, bus.active}, 32'h8001);
      if (k == 11025) check("chord_end_active", {16'h0, bus.active}, 0);
      if (bus.active == 16'h8001 && bus.sample != 16'sd4094 &&
          bus.sample != 16'sd0 && bus.sample != -16'sd4094) bad++;
    end
    check("chord_value_set", bad, 0);
    bad = 0;
    while (e < 20000) begin
      tick();
      if (bus.active != 16'h0) bad++;
    end
    check("held_no_refire", bad, 0);
    check("held_silent", $signed(bus.sample), 0);
    bus.trig = 16'h0000;
    tick();

    // Mute at +300 with a simultaneous rising trigger on voice 1
    pulse_v0();
    tick_to(299);
    bus.mute = 1'b1;
    bus.trig = 16'h0002;
    tick();
    bus.mute = 1'b0;
    bus.trig = 16'h0000;
    check("mute_active", {16'h0, bus.active}, 0);
    check("mute_sample_lag", $signed(bus.sample), 2047);
    tick();
    check("mute_sample", $signed(bus.sample), 0);
    tick();
    check("mute_trig_ignored", {16'h0, bus.active}, 0);

    // Reset mid-note with trig held high: fires again after release
    bus.trig = 16'h0001;
    e = -1;
    tick();
    tick_to(50);
    resetn = 1'b0;
    tick();
    check("midrst_active", {16'h0, bus.active}, 0);
    check("midrst_sample", $signed(bus.sample), 0);
    resetn = 1'b1;
    tick();
    check("postrst_retrig", {16'h0, bus.active}, 32'h0001);
    check("postrst_sample", $signed(bus.sample), 0);
    tick();
    check("postrst_high", $signed(bus.sample), 2047);
    bus.trig = 16'h0000;

    // Saturation: all 16 voices at AMP=4095
    bus2.trig = 16'hFFFF;
    tick();
    bus2.trig = 16'h0000;
    check("sat_active", {16'h0, bus2.active}, 32'hFFFF);
    check("sat_sample_n", $signed(bus2.sample), 0);
    tick();
    check("sat_sample", $signed(bus2.sample), 32767);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
